// File: rtl/ex_mem_latch_pkg.sv
// ============================================================================
// Module      : ex_mem_latch_pkg
// Description : Branch-type and ALU Oper encodings shared with the ALU and
//               decoder, plus the EX/MEM control-state record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_latch_pkg;

  typedef enum logic [1:0] {
    BR_BEQZ = 2'b00,
    BR_BNEZ = 2'b01,
    BR_BLTZ = 2'b10,
    BR_BGEZ = 2'b11
  } br_type_e;

  localparam logic [3:0] c_OPER_ADD = 4'b0100;

  typedef struct packed {
    logic valid;
    logic reg_wen;
    logic mem_wen;
    logic mem_ren;
    logic br_taken;
    logic ofl_trap;
    logic kill_pending;
  } exmem_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
// Module      : dff
// Description : Enabled D flip-flop bank with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_latch_br_cond.sv
// ============================================================================
// Module      : br_cond
// Description : Combinational branch-condition evaluator on EX-stage flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_cond
  import ex_mem_latch_pkg::*;
(
  input  logic [1:0] ex_br_type,
  input  logic       ex_zero,
  input  logic       ex_neg,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(ex_br_type))
      BR_BEQZ: taken = ex_zero;
      BR_BNEZ: taken = ~ex_zero;
      BR_BLTZ: taken = ex_neg;
      BR_BGEZ: taken = ~ex_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_latch.sv
// ============================================================================
// Module      : ex_mem_latch
// Description : EX/MEM pipeline register with stall/flush, taken-branch kill
//               of the following slot, and optional overflow trap
//               (enabled by defining EXMEM_OFL_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_out,
  input  logic             ex_zero,
  input  logic             ex_neg,
  input  logic             ex_ofl,
  input  logic             ex_is_add,
  input  logic [2:0]       ex_wr_reg,
  input  logic             ex_reg_wen,
  input  logic             ex_mem_wen,
  input  logic             ex_mem_ren,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic             ex_is_branch,
  input  logic [1:0]       ex_br_type,
  input  logic [WIDTH-1:0] ex_br_target,
  input  logic             stall,
  input  logic             flush,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu_out,
  output logic [2:0]       mem_wr_reg,
  output logic             mem_reg_wen,
  output logic             mem_mem_wen,
  output logic             mem_mem_ren,
  output logic [WIDTH-1:0] mem_store_data,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_pc,
  output logic             ofl_trap
);

  localparam int c_CTRL_W = $bits(exmem_ctrl_t);
  localparam int c_DATA_W = 3 * WIDTH + 3;

  exmem_ctrl_t         w_ctrl_d;
  exmem_ctrl_t         r_ctrl_q;
  logic [c_DATA_W-1:0] w_data_d;
  logic [c_DATA_W-1:0] r_data_q;
  logic                w_en;
  logic                w_cond;
  logic                w_valid;
  logic                w_trap;
  logic                w_taken;

  br_cond u_br_cond (
    .ex_br_type (ex_br_type),
    .ex_zero    (ex_zero),
    .ex_neg     (ex_neg),
    .taken      (w_cond)
  );

  // Flush loads a bubble even while stalled.
  assign w_en    = flush | ~stall;
  assign w_valid = ex_valid & ~r_ctrl_q.kill_pending;
  assign w_taken = w_valid & ex_is_branch & w_cond;

`ifdef EXMEM_OFL_TRAP_EN
  assign w_trap = w_valid & ex_is_add & ex_ofl;
`else
  logic w_unused_ofl;
  assign w_trap       = 1'b0;
  assign w_unused_ofl = ex_ofl ^ ex_is_add;
`endif

  always_comb begin
    w_ctrl_d = '0;
    if (!flush) begin
      w_ctrl_d.valid        = w_valid;
      w_ctrl_d.reg_wen      = w_valid & ex_reg_wen & ~w_trap;
      w_ctrl_d.mem_wen      = w_valid & ex_mem_wen & ~w_trap;
      w_ctrl_d.mem_ren      = w_valid & ex_mem_ren;
      w_ctrl_d.br_taken     = w_taken;
      w_ctrl_d.ofl_trap     = w_trap;
      w_ctrl_d.kill_pending = w_taken;
    end
  end

  assign w_data_d = {ex_out, ex_store_data, ex_br_target, ex_wr_reg};

  dff #(.WIDTH(c_CTRL_W)) u_ctrl_dff (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .d   (w_ctrl_d),
    .q   (r_ctrl_q)
  );

  dff #(.WIDTH(c_DATA_W)) u_data_dff (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .d   (w_data_d),
    .q   (r_data_q)
  );

  assign mem_valid      = r_ctrl_q.valid;
  assign mem_reg_wen    = r_ctrl_q.reg_wen;
  assign mem_mem_wen    = r_ctrl_q.mem_wen;
  assign mem_mem_ren    = r_ctrl_q.mem_ren;
  assign br_taken       = r_ctrl_q.br_taken;
  assign ofl_trap       = r_ctrl_q.ofl_trap;
  assign mem_alu_out    = r_data_q[3*WIDTH+2 -: WIDTH];
  assign mem_store_data = r_data_q[2*WIDTH+2 -: WIDTH];
  assign br_pc          = r_data_q[WIDTH+2 -: WIDTH];
  assign mem_wr_reg     = r_data_q[2:0];

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
// ============================================================================
// Module      : tb_ex_mem_latch
// Description : Directed self-checking bench for ex_mem_latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_zero, ex_neg, ex_ofl, ex_is_add;
  logic [15:0] ex_out, ex_store_data, ex_br_target;
  logic [2:0]  ex_wr_reg;
  logic        ex_reg_wen, ex_mem_wen, ex_mem_ren, ex_is_branch;
  logic [1:0]  ex_br_type;
  logic        stall, flush;
  logic        mem_valid, mem_reg_wen, mem_mem_wen, mem_mem_ren;
  logic [15:0] mem_alu_out, mem_store_data, br_pc;
  logic [2:0]  mem_wr_reg;
  logic        br_taken, ofl_trap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(.WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_out         (ex_out),
    .ex_zero        (ex_zero),
    .ex_neg         (ex_neg),
    .ex_ofl         (ex_ofl),
    .ex_is_add      (ex_is_add),
    .ex_wr_reg      (ex_wr_reg),
    .ex_reg_wen     (ex_reg_wen),
    .ex_mem_wen     (ex_mem_wen),
    .ex_mem_ren     (ex_mem_ren),
    .ex_store_data  (ex_store_data),
    .ex_is_branch   (ex_is_branch),
    .ex_br_type     (ex_br_type),
    .ex_br_target   (ex_br_target),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_alu_out    (mem_alu_out),
    .mem_wr_reg     (mem_wr_reg),
    .mem_reg_wen    (mem_reg_wen),
    .mem_mem_wen    (mem_mem_wen),
    .mem_mem_ren    (mem_mem_ren),
    .mem_store_data (mem_store_data),
    .br_taken       (br_taken),
    .br_pc          (br_pc),
    .ofl_trap       (ofl_trap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_out = '0; ex_zero = 0; ex_neg = 0; ex_ofl = 0; ex_is_add = 0;
    ex_wr_reg = '0; ex_reg_wen = 0; ex_mem_wen = 0; ex_mem_ren = 0;
    ex_store_data = '0; ex_is_branch = 0; ex_br_type = '0; ex_br_target = '0;
  endtask

  // {br_type, zero, neg, expected taken}
  logic [4:0] br_vec [7];

  initial begin
    br_vec[0] = {2'b00, 1'b1, 1'b0, 1'b1};
    br_vec[1] = {2'b00, 1'b0, 1'b0, 1'b0};
    br_vec[2] = {2'b01, 1'b1, 1'b0, 1'b0};
    br_vec[3] = {2'b10, 1'b0, 1'b1, 1'b1};
    br_vec[4] = {2'b10, 1'b0, 1'b0, 1'b0};
    br_vec[5] = {2'b11, 1'b0, 1'b1, 1'b0};
    br_vec[6] = {2'b11, 1'b0, 1'b0, 1'b1};

    rst = 1; stall = 0; flush = 0;
    ex_idle();
    ex_valid = 1; ex_out = 16'hFFFF; ex_reg_wen = 1;
    step();
    check("rst_valid", mem_valid, 0);
    check("rst_alu", mem_alu_out, 0);
    check("rst_reg_wen", mem_reg_wen, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_ofl_trap", ofl_trap, 0);

    rst = 0;
    ex_idle();
    ex_valid = 1; ex_out = 16'h1234; ex_wr_reg = 3'd3; ex_reg_wen = 1;
    step();
    check("pass_alu", mem_alu_out, 16'h1234);
    check("pass_wr_reg", mem_wr_reg, 3);
    check("pass_reg_wen", mem_reg_wen, 1);
    check("pass_valid", mem_valid, 1);

    ex_idle();
    ex_valid = 1; ex_out = 16'hBEEF; ex_store_data = 16'h55AA; ex_mem_wen = 1;
    step();
    check("cap_alu", mem_alu_out, 16'hBEEF);
    check("cap_store", mem_store_data, 16'h55AA);
    check("cap_mem_wen", mem_mem_wen, 1);
    stall = 1;
    ex_out = 16'hDEAD; ex_store_data = 16'h0000; ex_mem_wen = 0; ex_reg_wen = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_alu", mem_alu_out, 16'hBEEF);
      check("stall_mem_wen", mem_mem_wen, 1);
      check("stall_reg_wen", mem_reg_wen, 0);
    end
    flush = 1; ex_mem_ren = 1; ex_mem_wen = 1;
    step();
    check("flush_valid", mem_valid, 0);
    check("flush_reg_wen", mem_reg_wen, 0);
    check("flush_mem_wen", mem_mem_wen, 0);
    check("flush_mem_ren", mem_mem_ren, 0);
    flush = 0; stall = 0;

    ex_idle();
    ex_reg_wen = 1; ex_mem_ren = 1; ex_mem_wen = 1;
    step();
    check("inval_reg_wen", mem_reg_wen, 0);
    check("inval_mem_ren", mem_mem_ren, 0);
    check("inval_mem_wen", mem_mem_wen, 0);

    ex_idle();
    ex_valid = 1; ex_is_branch = 1; ex_br_type = 2'b01; ex_br_target = 16'h0040;
    step();
    check("br_taken", br_taken, 1);
    check("br_pc", br_pc, 16'h0040);
    ex_idle();
    ex_valid = 1; ex_reg_wen = 1; ex_out = 16'h1111;
    stall = 1;
    step();
    check("br_stall_held", br_taken, 1);
    stall = 0;
    step();
    check("kill_valid", mem_valid, 0);
    check("kill_reg_wen", mem_reg_wen, 0);
    check("kill_br_drop", br_taken, 0);
    ex_out = 16'h2222;
    step();
    check("third_valid", mem_valid, 1);
    check("third_alu", mem_alu_out, 16'h2222);
    check("third_reg_wen", mem_reg_wen, 1);

    for (int i = 0; i < 7; i++) begin
      logic [4:0] v;
      v = br_vec[i];
      ex_idle();
      ex_valid = 1; ex_is_branch = 1; ex_br_type = v[4:3];
      ex_zero = v[2]; ex_neg = v[1]; ex_br_target = 16'h0100 + 16'(i);
      step();
      check($sformatf("br_cond_%0d", i), br_taken, v[0]);
      ex_idle();
      ex_valid = 1; ex_reg_wen = 1; ex_out = 16'(i);
      step();
      check($sformatf("br_follow_%0d", i), mem_valid, !v[0]);
    end

    ex_idle();
    ex_valid = 1; ex_is_branch = 1; ex_br_type = 2'b00; ex_zero = 1; ex_br_target = 16'h0080;
    step();
    check("rb_taken", br_taken, 1);
    rst = 1;
    ex_idle();
    step();
    check("rb_br_taken", br_taken, 0);
    check("rb_br_pc", br_pc, 0);
    check("rb_valid", mem_valid, 0);
    rst = 0;
    ex_valid = 1; ex_reg_wen = 1; ex_out = 16'h3333;
    step();
    check("rb_post_valid", mem_valid, 1);
    check("rb_post_alu", mem_alu_out, 16'h3333);

    ex_idle();
    ex_valid = 1; ex_is_add = 1; ex_ofl = 1; ex_reg_wen = 1; ex_mem_wen = 1;
    step();
    check("ofl_valid", mem_valid, 1);
`ifdef EXMEM_OFL_TRAP_EN
    check("ofl_trap", ofl_trap, 1);
    check("ofl_reg_wen", mem_reg_wen, 0);
    check("ofl_mem_wen", mem_mem_wen, 0);
`else
    check("ofl_trap", ofl_trap, 0);
    check("ofl_reg_wen", mem_reg_wen, 1);
    check("ofl_mem_wen", mem_mem_wen, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
